// File: rtl/rv_pkg.sv
// Purpose: shared RV32 fetch-side definitions: opcodes, NOP, immediates, IF/ID record.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rv_pkg;

   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_JALR   = 7'b1100111;
   localparam logic [31:0] NOP_INSTR  = 32'h00000013;   // addi x0, x0, 0

   // IF/ID pipeline register contents
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred_taken;
   } ifid_t;

   // J-type immediate, sign-extended, bit 0 implicitly zero
   function automatic logic [31:0] imm_j(input logic [31:0] instr);
      return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

   // B-type immediate, sign-extended, bit 0 implicitly zero
   function automatic logic [31:0] imm_b(input logic [31:0] instr);
      return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/static_bpred.sv
// Purpose: static branch predictor; JAL and backward conditional branches are taken.
// Latency: purely combinational.
// Backpressure: none; the caller gates the result.
//
// Ports:
//   pc     in  32  PC of the instruction being decoded
//   instr  in  32  instruction word
//   taken  out  1  predicted taken
//   target out 32  predicted target (pc + immediate), valid when taken=1
module static_bpred
   import rv_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   output logic        taken,
   output logic [31:0] target
);

   always_comb begin
      taken  = 1'b0;
      target = '0;
      case (instr[6:0])
         OPC_JAL: begin
            taken  = 1'b1;
            target = pc + imm_j(instr);
         end
         OPC_BRANCH: begin
            // backward branches (negative offset) are usually loop closers
            taken  = instr[31];
            target = pc + imm_b(instr);
         end
         OPC_JALR: begin
            // register-indirect target is unknown here; resolved in execute
            taken  = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/if_stage.sv
// Purpose: instruction fetch stage: imem addressing, response alignment, static prediction, IF/ID register.
// Latency: imem word registered into IF/ID one cycle after it returns (two cycles after pc_i).
// Backpressure: stall_i holds IF/ID and drops the in-flight word; flush_i squashes; predicted jumps kill the next word.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   pc_i / imem_addr_o          fetch PC in, passed straight to instruction memory
//   imem_rdata_i                word for the address presented last cycle
//   stall_i, flush_i            load-use stall, execute-stage redirect
//   pred_jump_o, pred_target_o  redirect to the PC register
//   id_valid_o, id_pc_o, id_instr_o, id_pred_taken_o   IF/ID register
//   pred_cnt_o                  saturating count of taken predictions
module if_stage
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0,
   parameter bit          PREDICT_EN = 1'b1,
   parameter int          CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      pc_i,
   output logic [31:0]      imem_addr_o,
   input  logic [31:0]      imem_rdata_i,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic             pred_jump_o,
   output logic [31:0]      pred_target_o,
   output logic             id_valid_o,
   output logic [31:0]      id_pc_o,
   output logic [31:0]      id_instr_o,
   output logic             id_pred_taken_o,
   output logic [CNT_W-1:0] pred_cnt_o
);

   logic [31:0]      pc_q;      // PC whose word is on imem_rdata_i this cycle
   logic             rsp_v_q;   // a response exists (not the first cycle after reset)
   logic             kill_q;    // the returning word is from a wrong-path address
   ifid_t            id_q;
   logic [CNT_W-1:0] cnt_q;

   logic             live;
   logic             bp_taken;
   logic [31:0]      bp_target;
   logic             pred_jump;

   static_bpred u_bpred (
      .pc     (pc_q),
      .instr  (imem_rdata_i),
      .taken  (bp_taken),
      .target (bp_target)
   );

   assign imem_addr_o = pc_i;
   assign live        = rsp_v_q & ~kill_q;

   // A stalled word is refetched, so predicting it now would redirect twice.
   assign pred_jump     = PREDICT_EN & live & bp_taken & ~stall_i & ~flush_i;
   assign pred_target_o = pred_jump ? bp_target : '0;
   assign pred_jump_o   = pred_jump;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         rsp_v_q <= 1'b0;
         kill_q  <= 1'b0;
         cnt_q   <= '0;
         id_q    <= '{valid: 1'b0, pc: RESET_PC, instr: NOP_INSTR, pred_taken: 1'b0};
      end else begin
         pc_q    <= pc_i;
         rsp_v_q <= 1'b1;
         // The flush redirect lands one cycle later at the PC register, so
         // either way exactly one in-flight word must be dropped.
         kill_q  <= pred_jump | flush_i;

         if (pred_jump && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);

         if (flush_i) begin
            id_q.valid      <= 1'b0;
            id_q.instr      <= NOP_INSTR;
            id_q.pred_taken <= 1'b0;
         end else if (stall_i) begin
            // hold IF/ID; the PC register rewinds and refetches this word
         end else if (live) begin
            id_q <= '{valid: 1'b1, pc: pc_q, instr: imem_rdata_i, pred_taken: pred_jump};
         end else begin
            id_q.valid      <= 1'b0;
            id_q.instr      <= NOP_INSTR;
            id_q.pred_taken <= 1'b0;
         end
      end
   end

   assign id_valid_o      = id_q.valid;
   assign id_pc_o         = id_q.pc;
   assign id_instr_o      = id_q.instr;
   assign id_pred_taken_o = id_q.pred_taken;
   assign pred_cnt_o      = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Purpose: directed self-checking bench for if_stage with an IF/ID scoreboard queue.
// Latency: each step drives one cycle; IF/ID expectations are popped after the edge.
// Backpressure: stall/flush/kill scenarios are driven as directed steps.
module tb_if_stage;

   localparam int CNT_W = 2;   // small so saturation is reachable

   localparam logic [31:0] W_A     = 32'h00100093;
   localparam logic [31:0] W_B     = 32'h00200113;
   localparam logic [31:0] W_JAL16 = 32'h0100006F;   // jal x0, +16
   localparam logic [31:0] W_BEQB  = 32'hFE000CE3;   // beq x0,x0,-8
   localparam logic [31:0] W_BEQF  = 32'h00000463;   // beq x0,x0,+8
   localparam logic [31:0] NOP     = 32'h00000013;

   typedef struct {
      logic             valid;
      logic [31:0]      pc;
      logic [31:0]      instr;
      logic             taken;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      pc_i;
   logic [31:0]      imem_addr_o;
   logic [31:0]      imem_rdata_i;
   logic             stall_i;
   logic             flush_i;
   logic             pred_jump_o;
   logic [31:0]      pred_target_o;
   logic             id_valid_o;
   logic [31:0]      id_pc_o;
   logic [31:0]      id_instr_o;
   logic             id_pred_taken_o;
   logic [CNT_W-1:0] pred_cnt_o;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   if_stage #(.RESET_PC(32'h0), .PREDICT_EN(1'b1), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .pc_i            (pc_i),
      .imem_addr_o     (imem_addr_o),
      .imem_rdata_i    (imem_rdata_i),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .pred_jump_o     (pred_jump_o),
      .pred_target_o   (pred_target_o),
      .id_valid_o      (id_valid_o),
      .id_pc_o         (id_pc_o),
      .id_instr_o      (id_instr_o),
      .id_pred_taken_o (id_pred_taken_o),
      .pred_cnt_o      (pred_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      assert (act === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_id(input string tag, input exp_t e);
      chk({tag, ".id_valid"}, {31'b0, id_valid_o}, {31'b0, e.valid});
      chk({tag, ".id_pc"}, id_pc_o, e.pc);
      chk({tag, ".id_instr"}, id_instr_o, e.instr);
      chk({tag, ".id_pred_taken"}, {31'b0, id_pred_taken_o}, {31'b0, e.taken});
      chk({tag, ".pred_cnt"}, {{(32-CNT_W){1'b0}}, pred_cnt_o}, {{(32-CNT_W){1'b0}}, e.cnt});
   endtask

   // One cycle: drive, check combinational outputs, push the expected IF/ID
   // state, clock, then pop and compare.
   task automatic step(input string tag,
                       input logic [31:0] pc, input logic [31:0] rdata,
                       input logic st, input logic fl,
                       input logic ej, input logic [31:0] et,
                       input logic v, input logic [31:0] ipc, input logic [31:0] ins,
                       input logic tk, input logic [CNT_W-1:0] cnt);
      exp_t e;
      exp_t got;
      pc_i         = pc;
      imem_rdata_i = rdata;
      stall_i      = st;
      flush_i      = fl;
      #1;
      chk({tag, ".imem_addr"}, imem_addr_o, pc);
      chk({tag, ".pred_jump"}, {31'b0, pred_jump_o}, {31'b0, ej});
      chk({tag, ".pred_target"}, pred_target_o, et);
      e.valid = v; e.pc = ipc; e.instr = ins; e.taken = tk; e.cnt = cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk_id(tag, got);
   endtask

   initial begin
      exp_t r;
      r.valid = 1'b0; r.pc = 32'h0; r.instr = NOP; r.taken = 1'b0; r.cnt = '0;

      rst = 1'b1; pc_i = 32'h0; imem_rdata_i = 32'hDEADBEEF;
      stall_i = 1'b0; flush_i = 1'b0;
      #2;
      chk_id("reset", r);
      chk("reset.pred_jump", {31'b0, pred_jump_o}, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      //    tag        pc        rdata     st fl pj tgt          v  id_pc     instr    tk cnt
      // rdata in cycle 1 looks like a JAL but there is no response yet
      step("c1",  32'h00, 32'hDEADBEEF, 0, 0, 0, 32'h0,   0, 32'h00, NOP,     0, 0);
      step("c2",  32'h04, W_A,          0, 0, 0, 32'h0,   1, 32'h00, W_A,     0, 0);
      step("c3",  32'h08, W_B,          0, 0, 0, 32'h0,   1, 32'h04, W_B,     0, 0);
      step("jal", 32'h0C, W_JAL16,      0, 0, 1, 32'h18,  1, 32'h08, W_JAL16, 1, 1);
      // wrong-path word is itself a JAL: must be killed, not predicted
      step("kil", 32'h18, W_JAL16,      0, 0, 0, 32'h0,   0, 32'h08, NOP,     0, 1);
      step("c6",  32'h1C, W_A,          0, 0, 0, 32'h0,   1, 32'h18, W_A,     0, 1);
      step("c7",  32'h20, W_B,          0, 0, 0, 32'h0,   1, 32'h1C, W_B,     0, 1);
      step("bwd", 32'h24, W_BEQB,       0, 0, 1, 32'h18,  1, 32'h20, W_BEQB,  1, 2);
      step("kl2", 32'h18, W_B,          0, 0, 0, 32'h0,   0, 32'h20, NOP,     0, 2);
      step("c10", 32'h1C, W_A,          0, 0, 0, 32'h0,   1, 32'h18, W_A,     0, 2);
      step("c11", 32'h20, W_B,          0, 0, 0, 32'h0,   1, 32'h1C, W_B,     0, 2);
      step("fwd", 32'h24, W_BEQF,       0, 0, 0, 32'h0,   1, 32'h20, W_BEQF,  0, 2);
      step("c13", 32'h28, W_A,          0, 0, 0, 32'h0,   1, 32'h24, W_A,     0, 2);
      // two-cycle stall while the JAL at 0x28 returns; IF/ID holds
      step("st1", 32'h2C, W_JAL16,      1, 0, 0, 32'h0,   1, 32'h24, W_A,     0, 2);
      step("st2", 32'h28, W_B,          1, 0, 0, 32'h0,   1, 32'h24, W_A,     0, 2);
      step("rjl", 32'h2C, W_JAL16,      0, 0, 1, 32'h38,  1, 32'h28, W_JAL16, 1, 3);
      step("kl3", 32'h38, W_B,          0, 0, 0, 32'h0,   0, 32'h28, NOP,     0, 3);
      step("c18", 32'h3C, W_A,          0, 0, 0, 32'h0,   1, 32'h38, W_A,     0, 3);
      // flush with stall and a taken JAL: flush wins, no prediction
      step("fls", 32'h40, W_JAL16,      1, 1, 0, 32'h0,   0, 32'h38, NOP,     0, 3);
      step("kl4", 32'h100, W_JAL16,     0, 0, 0, 32'h0,   0, 32'h38, NOP,     0, 3);
      step("c21", 32'h104, W_A,         0, 0, 0, 32'h0,   1, 32'h100, W_A,    0, 3);
      // fourth prediction: counter saturates at all-ones
      step("sat", 32'h108, W_JAL16,     0, 0, 1, 32'h114, 1, 32'h104, W_JAL16, 1, 3);

      // asynchronous reset in the middle of a killed cycle
      pc_i = 32'h114; imem_rdata_i = W_JAL16; stall_i = 1'b0; flush_i = 1'b0;
      #1;
      chk("arst.pre_pred_jump", {31'b0, pred_jump_o}, 32'h0);
      chk("arst.pre_id_valid", {31'b0, id_valid_o}, 32'h1);
      #1;
      rst = 1'b1;
      #1;
      chk_id("arst", r);
      chk("arst.pred_jump", {31'b0, pred_jump_o}, 32'h0);
      chk("arst.pred_target", pred_target_o, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      step("r1",  32'h00, W_JAL16,      0, 0, 0, 32'h0,   0, 32'h00, NOP,     0, 0);
      step("r2",  32'h04, W_A,          0, 0, 0, 32'h0,   1, 32'h00, W_A,     0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Drives the synchronous instruction memory with the current PC and aligns the returned word with its PC.
- Performs static branch prediction and feeds the redirect back to the PC register (pc_jump / pc_i_jump).
- Holds the IF/ID pipeline register, with stall, flush and wrong-path kill handling.

Parameters:
- RESET_PC, 32'h0: PC value the PC register holds during reset; reset value of id_pc_o.
- PREDICT_EN, 1: 1 enables static prediction; 0 forces pred_jump_o=0.
- CNT_W, 16: width of the prediction performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- pc_i  in  32  current fetch PC from the PC register.
- imem_addr_o  out  32  instruction memory address; combinationally equal to pc_i.
- imem_rdata_i  in  32  instruction word for the address presented in the previous cycle.
- stall_i  in  1  load-use stall: hold IF/ID, discard the incoming response.
- flush_i  in  1  execute-stage redirect (mispredict or JALR): squash everything in the stage.
- pred_jump_o  out  1  to the PC register's pc_jump.
- pred_target_o  out  32  to the PC register's pc_i_jump.
- id_valid_o  out  1  IF/ID contents are a real instruction.
- id_pc_o  out  32  PC of id_instr_o; forwarded later as pc_not_jump.
- id_instr_o  out  32  instruction word; NOP 32'h00000013 when invalid.
- id_pred_taken_o  out  1  this instruction was predicted taken.
- pred_cnt_o  out  CNT_W  count of taken predictions since reset; saturating.

Behaviour:
- Response alignment:
  - pc_q <= pc_i every cycle.
  - rsp_v_q <= 1 every cycle after reset.
  - The response (pc_q, imem_rdata_i) is live when rsp_v_q=1 and kill_q=0.
- Static predictor (combinational on a live response):
  - JAL, opcode 1101111: taken, target = pc_q + sext(J-imm).
  - B-type, opcode 1100011, with instr[31]=1 (backward branch): taken, target = pc_q + sext(B-imm).
  - All other opcodes: not taken.
  - Addition is 32-bit, wrap-around, no overflow flag.
- Prediction is gated:
  - pred_jump_o = PREDICT_EN & live & taken & ~stall_i & ~flush_i.
  - pred_target_o = target when pred_jump_o=1, else 0.
- Wrong-path kill:
  - kill_q <= pred_jump_o | flush_i.
  - The word returning in the next cycle belongs to a wrong-path address and must be dropped.
  - The flush redirect takes one extra cycle at the PC register, so kill_q covers exactly the one in-flight word.
- IF/ID update, priority highest first:
  1. rst: id_valid_o=0, id_pc_o=RESET_PC, id_instr_o=NOP, id_pred_taken_o=0, pred_cnt_o=0, rsp_v_q=0, kill_q=0, pc_q=RESET_PC.
  2. flush_i: id_valid_o<=0, id_instr_o<=NOP, id_pred_taken_o<=0. Overrides stall_i and prediction in the same cycle.
  3. stall_i: all id_* hold; the incoming response is discarded, because the PC register rewinds and refetches it.
  4. live response: id_valid_o<=1, id_pc_o<=pc_q, id_instr_o<=imem_rdata_i, id_pred_taken_o<=pred_jump_o.
  5. otherwise (killed or first cycle after reset): id_valid_o<=0, id_instr_o<=NOP, id_pc_o holds.
- pred_cnt_o increments when pred_jump_o=1 and saturates at all-ones.
- The first live response appears in the second cycle after reset deassertion; no prediction occurs before it.
- Simultaneous stall_i and a taken candidate: no prediction. The instruction is refetched and predicted when stall_i is low.
- Asynchronous reset mid-stall or mid-kill clears all state immediately.
- No output depends combinationally on stall_i/flush_i except pred_jump_o and pred_target_o.

Decomposition:
- Shared package rv_pkg:
  - opcode constants OPC_JAL, OPC_BRANCH, OPC_JALR.
  - NOP_INSTR = 32'h00000013.
  - imm-extraction functions imm_j(), imm_b().
- One sub-module: static_bpred (pure combinational decode of instruction + pc into taken/target).
- The pipeline register and kill logic stay in if_stage.

Test Plan:
- Reset, then sequential words at pc 0,4,8:
  - id_valid_o first rises in the 2nd cycle after release, with id_pc_o=0.
  - id_pc_o then increments by 4; pred_jump_o stays 0.
- JAL +16 (32'h0100006F) returned for pc_q=8:
  - pred_jump_o=1 and pred_target_o=0x18 that cycle.
  - The next cycle's word is killed (id_valid_o=0).
  - pred_cnt_o=1.
- BEQ backward -8 (32'hFE000CE3) at pc_q=0x20: pred_target_o=0x18, id_pred_taken_o=1 one cycle later.
- BEQ forward +8 at pc_q=0x20: no prediction; id_pred_taken_o=0.
- stall_i high for 2 cycles while a JAL is returning:
  - id_* held at prior values; pred_jump_o=0.
  - After the stall, the refetched JAL predicts normally.
- flush_i asserted together with stall_i and a taken JAL:
  - id_valid_o=0 next cycle; pred_jump_o=0.
  - The following response is killed.
  - rst asserted mid-sequence returns all outputs to reset values asynchronously.
